// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage_pkg
// Brief   : Shared pipeline defines: datapath widths and ALU mode encodings.
// Rev     : 1.0
// ============================================================================
package id_ex_stage_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_MODE_W = 4;
  localparam int SHIFT_W    = 6;

  typedef enum logic [ALU_MODE_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_mode_e;

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module  : fwd_mux
// Brief   : Per-operand forwarding match and data select (nearest stage wins).
// Rev     : 1.0
// ============================================================================
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_addr,
  input  logic                  i_ignore,
  input  logic [XLEN-1:0]       i_rf_data,
  input  logic [REG_ADDR_W-1:0] i_fwd1_addr,
  input  logic                  i_fwd1_we,
  input  logic [XLEN-1:0]       i_fwd1_data,
  input  logic [REG_ADDR_W-1:0] i_fwd2_addr,
  input  logic                  i_fwd2_we,
  input  logic [XLEN-1:0]       i_fwd2_data,
  output logic [XLEN-1:0]       o_data,
  output logic                  o_match1,
  output logic                  o_match2
);

  logic w_addr_nz;

  // x0 is hardwired zero, so it never matches a producer
  assign w_addr_nz = (i_addr != '0) & ~i_ignore;
  assign o_match1  = w_addr_nz & i_fwd1_we & (i_fwd1_addr == i_addr);
  assign o_match2  = w_addr_nz & i_fwd2_we & (i_fwd2_addr == i_addr);

  always_comb begin
    o_data = i_rf_data;
    if (o_match1) begin
      o_data = i_fwd1_data;
    end else if (o_match2) begin
      o_data = i_fwd2_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage
// Brief   : ID/EX pipeline register with operand forwarding and hazard stall.
//           ID_EX_FORWARD_EN defined enables forwarding; otherwise any
//           producer match stalls until it clears.
// Rev     : 1.0
// ============================================================================
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic                  id_use_imm,
  input  logic [ALU_MODE_W-1:0] id_alu_mode,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_rd_we,
  input  logic [REG_ADDR_W-1:0] fwd1_rd_addr,
  input  logic                  fwd1_we,
  input  logic                  fwd1_is_load,
  input  logic [XLEN-1:0]       fwd1_data,
  input  logic [REG_ADDR_W-1:0] fwd2_rd_addr,
  input  logic                  fwd2_we,
  input  logic [XLEN-1:0]       fwd2_data,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_operand,
  output logic [XLEN-1:0]       ex_operand_b,
  output logic [SHIFT_W-1:0]    ex_shift_time,
  output logic [ALU_MODE_W-1:0] ex_alu_mode,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_rd_we,
  output logic                  hazard_stall
);

  logic [XLEN-1:0]       w_a_data;
  logic [XLEN-1:0]       w_b_data;
  logic                  w_a_m1;
  logic                  w_a_m2;
  logic                  w_b_m1;
  logic                  w_b_m2;
  logic [XLEN-1:0]       w_a_sel;
  logic [XLEN-1:0]       w_rs2_sel;
  logic [XLEN-1:0]       w_b_sel;
  logic                  w_hazard;

  logic                  r_valid;
  logic [XLEN-1:0]       r_operand_a;
  logic [XLEN-1:0]       r_operand_b;
  logic [SHIFT_W-1:0]    r_shift;
  logic [ALU_MODE_W-1:0] r_alu_mode;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic                  r_rd_we;

  fwd_mux u_fwd_a (
    .i_addr      (id_rs1_addr),
    .i_ignore    (1'b0),
    .i_rf_data   (id_rs1_data),
    .i_fwd1_addr (fwd1_rd_addr),
    .i_fwd1_we   (fwd1_we),
    .i_fwd1_data (fwd1_data),
    .i_fwd2_addr (fwd2_rd_addr),
    .i_fwd2_we   (fwd2_we),
    .i_fwd2_data (fwd2_data),
    .o_data      (w_a_data),
    .o_match1    (w_a_m1),
    .o_match2    (w_a_m2)
  );

  fwd_mux u_fwd_b (
    .i_addr      (id_rs2_addr),
    .i_ignore    (id_use_imm),
    .i_rf_data   (id_rs2_data),
    .i_fwd1_addr (fwd1_rd_addr),
    .i_fwd1_we   (fwd1_we),
    .i_fwd1_data (fwd1_data),
    .i_fwd2_addr (fwd2_rd_addr),
    .i_fwd2_we   (fwd2_we),
    .i_fwd2_data (fwd2_data),
    .o_data      (w_b_data),
    .o_match1    (w_b_m1),
    .o_match2    (w_b_m2)
  );

`ifdef ID_EX_FORWARD_EN
  logic w_unused_m2;
  assign w_unused_m2 = w_a_m2 ^ w_b_m2;
  assign w_a_sel     = w_a_data;
  assign w_rs2_sel   = w_b_data;
  // A load in the next stage has no data yet, so its consumer must wait
  assign w_hazard    = id_valid & fwd1_is_load & (w_a_m1 | w_b_m1);
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd1_is_load, w_a_data, w_b_data};
  assign w_a_sel      = id_rs1_data;
  assign w_rs2_sel    = id_rs2_data;
  assign w_hazard     = id_valid & (w_a_m1 | w_a_m2 | w_b_m1 | w_b_m2);
`endif

  assign w_b_sel      = id_use_imm ? id_imm : w_rs2_sel;
  assign hazard_stall = stall_in | w_hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_operand_a <= '0;
      r_operand_b <= '0;
      r_shift     <= '0;
      r_alu_mode  <= '0;
      r_rd_addr   <= '0;
      r_rd_we     <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_rd_we <= 1'b0;
    end else if (!stall_in) begin
      r_valid     <= id_valid & ~w_hazard;
      r_rd_we     <= id_valid & ~w_hazard & id_rd_we;
      r_operand_a <= w_a_sel;
      r_operand_b <= w_b_sel;
      r_shift     <= {1'b0, w_b_sel[4:0]};
      r_alu_mode  <= id_alu_mode;
      r_rd_addr   <= id_rd_addr;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_operand    = r_operand_a;
  assign ex_operand_b  = r_operand_b;
  assign ex_shift_time = r_shift;
  assign ex_alu_mode   = r_alu_mode;
  assign ex_rd_addr    = r_rd_addr;
  assign ex_rd_we      = r_rd_we;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_ex_stage
// Brief   : Self-checking bench for id_ex_stage against a rule-level model.
// Rev     : 1.0
// ============================================================================
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_imm, id_rd_we;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [3:0]  id_alu_mode;
  logic [4:0]  fwd1_rd_addr, fwd2_rd_addr;
  logic        fwd1_we, fwd1_is_load, fwd2_we;
  logic [31:0] fwd1_data, fwd2_data;
  logic        stall_in, flush;
  logic        ex_valid, ex_rd_we, hazard_stall;
  logic [31:0] ex_operand, ex_operand_b;
  logic [5:0]  ex_shift_time;
  logic [3:0]  ex_alu_mode;
  logic [4:0]  ex_rd_addr;

  int checks = 0;
  int errors = 0;

  // Expected EX-side state
  logic        m_valid, m_we;
  logic [31:0] m_a, m_b;
  logic [5:0]  m_shift;
  logic [3:0]  m_mode;
  logic [4:0]  m_rd;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_mode(id_alu_mode), .id_rd_addr(id_rd_addr),
    .id_rd_we(id_rd_we),
    .fwd1_rd_addr(fwd1_rd_addr), .fwd1_we(fwd1_we), .fwd1_is_load(fwd1_is_load),
    .fwd1_data(fwd1_data), .fwd2_rd_addr(fwd2_rd_addr), .fwd2_we(fwd2_we),
    .fwd2_data(fwd2_data), .stall_in(stall_in), .flush(flush),
    .ex_valid(ex_valid), .ex_operand(ex_operand), .ex_operand_b(ex_operand_b),
    .ex_shift_time(ex_shift_time), .ex_alu_mode(ex_alu_mode),
    .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit hit1(input logic [4:0] a);
    return (a != 5'd0) && fwd1_we && (fwd1_rd_addr == a);
  endfunction

  function automatic bit hit2(input logic [4:0] a);
    return (a != 5'd0) && fwd2_we && (fwd2_rd_addr == a);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
`ifdef ID_EX_FORWARD_EN
    if (hit1(a)) return fwd1_data;
    if (hit2(a)) return fwd2_data;
`endif
    return rf;
  endfunction

  function automatic bit hazard_now();
    bit uses_rs2 = !id_use_imm;
    if (!id_valid) return 1'b0;
`ifdef ID_EX_FORWARD_EN
    return fwd1_is_load && (hit1(id_rs1_addr) || (uses_rs2 && hit1(id_rs2_addr)));
`else
    return hit1(id_rs1_addr) || hit2(id_rs1_addr) ||
           (uses_rs2 && (hit1(id_rs2_addr) || hit2(id_rs2_addr)));
`endif
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_a = 0; m_b = 0; m_shift = 0; m_mode = 0; m_rd = 0;
  endtask

  task automatic check_outputs(input string tag, input bit all_fields);
    chk({tag, "/valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, "/rd_we"}, 32'(ex_rd_we), 32'(m_we));
    if (all_fields || m_valid) begin
      chk({tag, "/opA"},   ex_operand, m_a);
      chk({tag, "/opB"},   ex_operand_b, m_b);
      chk({tag, "/shift"}, 32'(ex_shift_time), 32'(m_shift));
      chk({tag, "/mode"},  32'(ex_alu_mode), 32'(m_mode));
      chk({tag, "/rd"},    32'(ex_rd_addr), 32'(m_rd));
    end
  endtask

  // Inputs are applied just after a rising edge; this checks the
  // combinational stall, crosses the next edge and checks the registers.
  task automatic cycle(input string tag);
    bit          hz = hazard_now();
    logic [31:0] a = operand(id_rs1_addr, id_rs1_data);
    logic [31:0] b = id_use_imm ? id_imm : operand(id_rs2_addr, id_rs2_data);
    #3;
    chk({tag, "/hazard_stall"}, 32'(hazard_stall), 32'(stall_in || hz));
    @(posedge clk);
    if (flush) begin
      m_valid = 0; m_we = 0;
    end else if (!stall_in) begin
      if (!id_valid || hz) begin
        m_valid = 0; m_we = 0;
      end else begin
        m_valid = 1; m_we = id_rd_we;
        m_a = a; m_b = b; m_shift = {1'b0, b[4:0]};
        m_mode = id_alu_mode; m_rd = id_rd_addr;
      end
    end
    #1;
    check_outputs(tag, 1'b0);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_use_imm = 0; id_rd_we = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_mode = 0;
    fwd1_rd_addr = 0; fwd1_we = 0; fwd1_is_load = 0; fwd1_data = 0;
    fwd2_rd_addr = 0; fwd2_we = 0; fwd2_data = 0;
    stall_in = 0; flush = 0;
  endtask

  task automatic load_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic [3:0] mode, input logic [4:0] rd);
    id_valid = 1; id_use_imm = 0; id_rd_we = 1;
    id_rs1_addr = rs1; id_rs2_addr = rs2; id_rs1_data = d1; id_rs2_data = d2;
    id_alu_mode = mode; id_rd_addr = rd;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    check_outputs("reset", 1'b1);
    rst = 0;

    // Plain load of an arithmetic right shift
    load_instr(5'd1, 5'd2, 32'h8000_0001, 32'd4, ALU_SRA, 5'd3);
    cycle("plain");
    chk("plain/opA_const", ex_operand, 32'h8000_0001);
    chk("plain/shift_const", 32'(ex_shift_time), 32'd4);
    chk("plain/valid_const", 32'(ex_valid), 32'd1);

    // Both producers hold rs1
    load_instr(5'd5, 5'd0, 32'h0BAD_0BAD, 32'd9, ALU_ADD, 5'd6);
    fwd1_rd_addr = 5; fwd1_we = 1; fwd1_data = 32'hAAAA_0000;
    fwd2_rd_addr = 5; fwd2_we = 1; fwd2_data = 32'h0000_1234;
    cycle("double");
`ifdef ID_EX_FORWARD_EN
    chk("double/opA_const", ex_operand, 32'hAAAA_0000);
`else
    chk("double/bubble_const", 32'(ex_valid), 32'd0);
`endif

    // Load-use on rs2, then the load data arrives from two stages ahead
    idle_inputs();
    load_instr(5'd0, 5'd7, 32'd0, 32'h5555_5555, ALU_SLL, 5'd8);
    fwd1_rd_addr = 7; fwd1_we = 1; fwd1_is_load = 1; fwd1_data = 32'hDEAD_BEEF;
    cycle("loaduse");
    chk("loaduse/bubble_const", 32'(ex_valid), 32'd0);
    fwd1_we = 0; fwd1_is_load = 0;
    fwd2_rd_addr = 7; fwd2_we = 1; fwd2_data = 32'h0000_001F;
    cycle("loaduse2");

    // Writes to x0 are never forwarded
    idle_inputs();
    load_instr(5'd0, 5'd0, 32'h1357_9BDF, 32'd2, ALU_OR, 5'd4);
    fwd1_rd_addr = 0; fwd1_we = 1; fwd1_is_load = 1; fwd1_data = 32'hFFFF_FFFF;
    cycle("x0");
    chk("x0/opA_const", ex_operand, 32'h1357_9BDF);

    // Downstream hold with changing ID inputs, then flush under stall
    idle_inputs();
    load_instr(5'd9, 5'd10, 32'h0000_00A5, 32'h0000_0023, ALU_SRL, 5'd11);
    cycle("preload");
    stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      load_instr(5'(i + 12), 5'(i + 13), $urandom, $urandom, 4'(i), 5'(i + 1));
      cycle("stall");
    end
    flush = 1;
    cycle("flush_stall");
    flush = 0; stall_in = 0;

    // Asynchronous reset mid-cycle while EX holds a valid instruction
    load_instr(5'd14, 5'd15, 32'h0F0F_0F0F, 32'h0000_0011, ALU_XOR, 5'd16);
    cycle("prereset");
    stall_in = 1;
    #2 rst = 1;
    model_reset();
    #1;
    check_outputs("async_reset", 1'b1);
    rst = 0;
    stall_in = 0;
    load_instr(5'd17, 5'd18, 32'h2222_2222, 32'h0000_0003, ALU_SUB, 5'd19);
    cycle("after_reset");

    // Randomized traffic with dense register-address collisions
    for (int i = 0; i < 400; i++) begin
      id_valid     = ($urandom_range(0, 7) != 0);
      id_use_imm   = $urandom_range(0, 1);
      id_rd_we     = $urandom_range(0, 1);
      id_rs1_addr  = 5'($urandom_range(0, 3));
      id_rs2_addr  = 5'($urandom_range(0, 3));
      id_rd_addr   = 5'($urandom);
      id_rs1_data  = $urandom;
      id_rs2_data  = $urandom;
      id_imm       = $urandom;
      id_alu_mode  = 4'($urandom);
      fwd1_rd_addr = 5'($urandom_range(0, 3));
      fwd1_we      = $urandom_range(0, 1);
      fwd1_is_load = ($urandom_range(0, 3) == 0);
      fwd1_data    = $urandom;
      fwd2_rd_addr = 5'($urandom_range(0, 3));
      fwd2_we      = $urandom_range(0, 1);
      fwd2_data    = $urandom;
      stall_in     = ($urandom_range(0, 5) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have ports: clk  input  1  rising-edge clock; rst  input  1  asynchronous, active-high reset.
REQ-002 The block SHALL have ID-side inputs: id_valid 1, id_rs1_addr 5, id_rs2_addr 5, id_rs1_data 32, id_rs2_data 32, id_imm 32, id_use_imm 1 (B from imm), id_alu_mode 4, id_rd_addr 5, id_rd_we 1.
REQ-003 The block SHALL have forwarding inputs: fwd1_rd_addr 5, fwd1_we 1, fwd1_is_load 1, fwd1_data 32 (stage one ahead); fwd2_rd_addr 5, fwd2_we 1, fwd2_data 32 (stage two ahead).
REQ-004 The block SHALL have control inputs: stall_in 1 (downstream hold), flush 1 (kill younger instruction).
REQ-005 The block SHALL have outputs: ex_valid 1, ex_operand 32 (A, to shifter operand), ex_operand_b 32, ex_shift_time 6, ex_alu_mode 4, ex_rd_addr 5, ex_rd_we 1, hazard_stall 1 (combinational, to IF/ID hold).

Function
REQ-006 Registered outputs SHALL update on rising clk; ID-to-EX latency exactly 1 cycle.
REQ-007 Update priority SHALL be: rst > flush > stall_in > hazard bubble > load of ID fields.
REQ-008 flush=1 SHALL clear ex_valid and ex_rd_we next cycle, even with stall_in=1; data fields don't-care.
REQ-009 stall_in=1 (no flush) SHALL hold every registered output unchanged; hazard_stall SHALL be 1.
REQ-010 Match on source s SHALL mean: addr_s != 0, fwdN_we=1, fwdN_rd_addr == addr_s; rs2 match ignored when id_use_imm=1.
REQ-011 Operand A/B SHALL select fwd1_data on fwd1 match, else fwd2_data on fwd2 match, else id_rsN_data; fwd1 wins when both match.
REQ-012 Load-use (fwd1 match with fwd1_is_load=1, id_valid=1) SHALL assert hazard_stall and load a bubble (ex_valid=0, ex_rd_we=0) for that cycle.
REQ-013 ex_operand_b SHALL be id_imm when id_use_imm=1, else forwarded rs2 value.
REQ-014 ex_shift_time SHALL be {1'b0, B[4:0]} of the selected B value; bit 5 never set.
REQ-015 id_valid=0 SHALL load a bubble; hazard_stall SHALL never assert for an invalid ID slot.
REQ-016 Register address 0 SHALL never be forwarded nor cause a hazard.

Reset
REQ-017 rst=1 SHALL immediately clear ex_valid, ex_rd_we, ex_operand, ex_operand_b, ex_shift_time, ex_alu_mode, ex_rd_addr to 0, independent of clk.
REQ-018 Reset deassertion SHALL make the first following edge a normal load; reset mid-stall SHALL discard held content.

Configuration
REQ-019 Macro ID_EX_FORWARD_EN defined: REQ-010..012 forwarding active.
REQ-020 Macro ID_EX_FORWARD_EN undefined: operands SHALL come from id_rsN_data only; any fwd1 or fwd2 match SHALL assert hazard_stall and load a bubble until no match remains.

Structure
REQ-021 ALU_mode encodings (SLL, SRL, SRA, etc.) and width constants SHALL reside in the shared pipeline defines package, not in this module.
REQ-022 Operand selection SHALL be one sub-module fwd_mux, instantiated twice (A and B).

Verification
REQ-023 Plain load: rs1_data=0x8000_0001, rs2_data=4, alu_mode=SRA, no matches -> next cycle ex_operand=0x8000_0001, ex_shift_time=6'd4, ex_valid=1.
REQ-024 Double match: rs1=5, fwd1 rd=5 data=0xAAAA_0000, fwd2 rd=5 data=0x1234 -> ex_operand=0xAAAA_0000.
REQ-025 Load-use: rs2=7, fwd1 rd=7 is_load=1 -> hazard_stall=1, next ex_valid=0; next cycle fwd2 rd=7 data=0x1F -> ex_operand_b=0x1F, ex_shift_time=6'd31.
REQ-026 x0: rs1=0, fwd1 rd=0 we=1 data=0xFFFF_FFFF -> ex_operand=id_rs1_data, hazard_stall=0.
REQ-027 stall_in=1 for 3 cycles with changing ID inputs -> outputs constant; flush with stall_in=1 -> ex_valid=0 next edge.
REQ-028 rst pulsed mid-cycle while ex_valid=1 -> all outputs 0 before next edge; with ID_EX_FORWARD_EN undefined, REQ-024 stimulus -> hazard_stall=1, bubble.
